// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_ctrl
//  Purpose  : Generates the DUTY_W-bit duty word for the PWM/LED dimmer.
//             Manual mode steps the duty with debounced up/down buttons
//             (saturating). Breathe mode ramps 0->max->0 continuously with
//             one step every STEP_CYCLES clocks.
//  Ports    : clk_i          system clock (rising edge)
//             reset_i        asynchronous active-high reset
//             btn_up_i       raw up button (asynchronous, bouncy)
//             btn_down_i     raw down button (asynchronous, bouncy)
//             mode_breathe_i raw slide switch, 0 = manual, 1 = breathe
//             duty_cycle_o   registered duty word
//             duty_changed_o one-cycle pulse when duty_cycle_o takes a new value
//             breathe_dir_o  1 while ramping up (registered)
//  Revision : 1.0  initial release
// ============================================================================
module pwm_duty_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 64,
  parameter int DUTY_W          = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              btn_up_i,
  input  logic              btn_down_i,
  input  logic              mode_breathe_i,
  output logic [DUTY_W-1:0] duty_cycle_o,
  output logic              duty_changed_o,
  output logic              breathe_dir_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int ST_W = $clog2(STEP_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]   ST_LAST  = ST_W'(STEP_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
  localparam int IDX_UP   = 0;
  localparam int IDX_DN   = 1;
  localparam int IDX_MODE = 2;

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } state_t;

  logic [2:0] raw_w;
  logic [2:0] level_w;
  logic [1:0] event_w;
  logic [1:0] live_q;

  assign raw_w = {mode_breathe_i, btn_down_i, btn_up_i};

  // Marks when the synchroniser outputs carry real samples rather than
  // their reset zeros (two clocks after reset release).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) live_q <= '0;
    else         live_q <= {live_q[0], 1'b1};
  end

  // Input conditioning: 2-FF synchroniser followed by a stability counter.
  for (genvar g = 0; g < 3; g++) begin : g_cond
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_w[g];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign level_w[g] = level_q;

    // Buttons only: a debounced rising edge becomes an event once the
    // button has been seen released after reset, so a button held through
    // reset cannot fire on release of reset.
    if (g < 2) begin : g_evt
      logic level_prev_q;
      logic armed_q;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          level_prev_q <= 1'b0;
          armed_q      <= 1'b0;
        end else begin
          level_prev_q <= level_q;
          if (live_q[1] && !sync2_q) armed_q <= 1'b1;
        end
      end

      assign event_w[g] = level_q & ~level_prev_q & armed_q;
    end
  end

  // Duty / mode state machine.
  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [ST_W-1:0]   pre_q, pre_d;
  logic              duty_changed_q;
  logic              breathe_dir_q;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pre_d   = pre_q;
    case (state_q)
      ST_MANUAL: begin
        pre_d = '0;
        if (level_w[IDX_MODE]) begin
          // Direction is chosen from the current duty; duty itself is kept.
          state_d = (duty_q == DUTY_MAX) ? ST_RAMP_DOWN : ST_RAMP_UP;
        end else if (event_w[IDX_UP] && !event_w[IDX_DN]) begin
          if (duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
        end else if (event_w[IDX_DN] && !event_w[IDX_UP]) begin
          if (duty_q != '0) duty_d = duty_q - 1'b1;
        end
      end
      ST_RAMP_UP: begin
        if (pre_q == ST_LAST) begin
          pre_d = '0;
          if (duty_q != DUTY_MAX) duty_d = duty_q + 1'b1;
          if (duty_q >= DUTY_MAX - 1'b1) state_d = ST_RAMP_DOWN;
        end else begin
          pre_d = pre_q + 1'b1;
        end
        // Leaving takes effect after any step of this same cycle.
        if (!level_w[IDX_MODE]) begin
          state_d = ST_MANUAL;
          pre_d   = '0;
        end
      end
      ST_RAMP_DOWN: begin
        if (pre_q == ST_LAST) begin
          pre_d = '0;
          if (duty_q != '0) duty_d = duty_q - 1'b1;
          if (duty_q <= 1) state_d = ST_RAMP_UP;
        end else begin
          pre_d = pre_q + 1'b1;
        end
        if (!level_w[IDX_MODE]) begin
          state_d = ST_MANUAL;
          pre_d   = '0;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        pre_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_MANUAL;
      duty_q         <= '0;
      pre_q          <= '0;
      duty_changed_q <= 1'b0;
      breathe_dir_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      duty_q         <= duty_d;
      pre_q          <= pre_d;
      duty_changed_q <= (duty_d != duty_q);
      breathe_dir_q  <= (state_d == ST_RAMP_UP);
    end
  end

  assign duty_cycle_o   = duty_q;
  assign duty_changed_o = duty_changed_q;
  assign breathe_dir_o  = breathe_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_duty_ctrl
//  Purpose  : Self-checking bench for pwm_duty_ctrl (DEBOUNCE_CYCLES=4,
//             STEP_CYCLES=8). Directed vector table, hand-written reset and
//             latency sequences, and random stimulus against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_duty_ctrl;
  localparam int D    = 4;
  localparam int S    = 8;
  localparam int W    = 4;
  localparam int MAXD = 15;
  localparam int HN   = 16384;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         up = 1'b0, dn = 1'b0, mode = 1'b0;
  logic [W-1:0] duty;
  logic         chg, dir;

  always #5 clk = ~clk;

  pwm_duty_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S), .DUTY_W(W)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .btn_up_i       (up),
    .btn_down_i     (dn),
    .mode_breathe_i (mode),
    .duty_cycle_o   (duty),
    .duty_changed_o (chg),
    .breathe_dir_o  (dir)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // ---------------- reference model ----------------
  // Raw input history per clock edge since reset release (index 1 = first edge).
  bit raw_h [3][HN];
  int m_edge;
  bit m_lvl [3];
  bit m_rose [2];
  bit m_seen [2];
  int m_duty;
  bit m_ramp, m_up, m_chg, m_dir;
  int m_rcnt;

  function automatic void model_reset();
    m_edge = 0;
    for (int g = 0; g < 3; g++) m_lvl[g] = 1'b0;
    for (int g = 0; g < 2; g++) begin m_rose[g] = 1'b0; m_seen[g] = 1'b0; end
    m_duty = 0; m_ramp = 1'b0; m_up = 1'b0; m_chg = 1'b0; m_dir = 1'b0; m_rcnt = 0;
  endfunction

  function automatic bit raw_at(int g, int idx);
    if (idx < 1) return 1'b0;
    return raw_h[g][idx];
  endfunction

  function automatic void model_edge(bit r0, bit r1, bit r2);
    int  old;
    bit  ev [2];
    bit  differ;
    m_edge++;
    if (m_edge < HN) begin
      raw_h[0][m_edge] = r0; raw_h[1][m_edge] = r1; raw_h[2][m_edge] = r2;
    end
    // A button press counts only after the button was seen released
    // (synchronised) since reset.
    for (int g = 0; g < 2; g++) begin
      if (m_edge - 3 >= 1 && !raw_at(g, m_edge - 3)) m_seen[g] = 1'b1;
      ev[g] = m_rose[g] && m_seen[g];
    end
    old = m_duty;
    if (!m_ramp) begin
      if (m_lvl[2]) begin
        m_ramp = 1'b1; m_up = (m_duty < MAXD); m_rcnt = 0;
      end else if (ev[0] && !ev[1]) begin
        m_duty = (m_duty < MAXD) ? m_duty + 1 : MAXD;
      end else if (ev[1] && !ev[0]) begin
        m_duty = (m_duty > 0) ? m_duty - 1 : 0;
      end
    end else begin
      m_rcnt++;
      if (m_rcnt % S == 0) begin
        m_duty = m_up ? m_duty + 1 : m_duty - 1;
        if (m_duty == MAXD) m_up = 1'b0;
        else if (m_duty == 0) m_up = 1'b1;
      end
      if (!m_lvl[2]) m_ramp = 1'b0;
    end
    m_chg = (m_duty != old);
    m_dir = m_ramp && m_up;
    // Debounced levels: flip when the last D synchronised samples
    // (raw delayed by two clocks) all disagree with the current level.
    for (int g = 0; g < 3; g++) begin
      differ = 1'b1;
      for (int j = 0; j < D; j++)
        if (raw_at(g, m_edge - 2 - j) == m_lvl[g]) differ = 1'b0;
      if (g < 2) m_rose[g] = differ && !m_lvl[g];
      if (differ) m_lvl[g] = ~m_lvl[g];
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    model_edge(up, dn, mode);
    @(posedge clk); #1;
    checks++;
    if (int'(duty) != m_duty || chg != m_chg || dir != m_dir) begin
      failures++;
      $display("FAIL model_step edge=%0d duty=%0d exp=%0d changed=%0b exp=%0b dir=%0b exp=%0b",
               m_edge, duty, m_duty, chg, m_chg, dir, m_dir);
    end
    pulses += int'(chg);
  endtask

  typedef struct {
    string name;
    bit    up, dn, mode;
    int    hold;
    int    exp_duty;
    int    exp_pulses;
    bit    exp_dir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, bit u, bit d, bit m, int h, int ed, int ep, bit edir);
    vec_t v;
    v.name = n; v.up = u; v.dn = d; v.mode = m; v.hold = h;
    v.exp_duty = ed; v.exp_pulses = ep; v.exp_dir = edir;
    vecs.push_back(v);
  endfunction

  task automatic apply_row(input vec_t v);
    up = v.up; dn = v.dn; mode = v.mode;
    pulses = 0;
    repeat (v.hold) cycle();
    check({v.name, "_duty"},   int'(duty), v.exp_duty);
    check({v.name, "_pulses"}, pulses,     v.exp_pulses);
    check({v.name, "_dir"},    int'(dir),  int'(v.exp_dir));
  endtask

  initial begin
    // ---- vector table ----
    add("release",  0, 0, 0, 8, 1, 0, 0);
    add("bounce2",  1, 0, 0, 2, 1, 0, 0);
    add("gap2",     0, 0, 0, 8, 1, 0, 0);
    add("bounce3",  1, 0, 0, 3, 1, 0, 0);
    add("gap3",     0, 0, 0, 8, 1, 0, 0);
    add("down_to0", 0, 1, 0, 8, 0, 1, 0);
    add("idle",     0, 0, 0, 8, 0, 0, 0);
    for (int p = 1; p <= 17; p++) begin
      add("up_press", 1, 0, 0, 8, (p < MAXD) ? p : MAXD, (p <= MAXD) ? 1 : 0, 0);
      add("idle",     0, 0, 0, 8, (p < MAXD) ? p : MAXD, 0, 0);
    end
    for (int p = 1; p <= 16; p++) begin
      add("dn_press", 0, 1, 0, 8, (MAXD - p > 0) ? MAXD - p : 0, (p <= MAXD) ? 1 : 0, 0);
      add("idle",     0, 0, 0, 8, (MAXD - p > 0) ? MAXD - p : 0, 0, 0);
    end
    for (int p = 1; p <= 13; p++) begin
      add("up_to13", 1, 0, 0, 8, p, 1, 0);
      add("idle",    0, 0, 0, 8, p, 0, 0);
    end
    add("both_press",  1, 1, 0, 8,   13, 0,  0);
    add("idle",        0, 0, 0, 8,   13, 0,  0);
    add("breathe_14",  0, 0, 1, 15,  14, 1,  1);
    add("breathe_15",  0, 0, 1, 8,   15, 1,  0);
    add("hold_max",    0, 0, 1, 8,   14, 1,  0);
    add("ramp_down",   0, 0, 1, 112, 0,  14, 1);
    add("rise_again",  0, 0, 1, 8,   1,  1,  1);
    add("to_nine",     0, 0, 1, 64,  9,  8,  1);
    add("mode_off",    0, 0, 0, 10,  9,  0,  0);
    add("up_after",    1, 0, 0, 8,   10, 1,  0);
    add("idle",        0, 0, 0, 8,   10, 0,  0);

    // ---- reset state ----
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_duty",    int'(duty), 0);
    check("reset_changed", int'(chg),  0);
    check("reset_dir",     int'(dir),  0);
    repeat (6) cycle();

    // ---- held button: exact latency, single pulse, no auto-repeat ----
    up = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 6) check("latency_before", int'(duty), 0);
      if (i == 7) begin
        check("latency_exact", int'(duty), 1);
        check("latency_pulse", int'(chg),  1);
      end
      if (i == 8) check("pulse_width", int'(chg), 0);
    end
    check("hold_no_repeat", pulses, 1);
    up = 1'b0;

    // ---- table ----
    foreach (vecs[i]) apply_row(vecs[i]);

    // ---- reset mid-ramp with up held ----
    mode = 1'b1;
    repeat (30) cycle();
    up = 1'b1;
    repeat (3) cycle();
    check("ramp_before_reset_nonzero", int'(duty != 0), 1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_duty",    int'(duty), 0);
    check("async_reset_dir",     int'(dir),  0);
    check("async_reset_changed", int'(chg),  0);
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (20) cycle();
    check("held_through_reset_duty",   int'(duty), 0);
    check("held_through_reset_pulses", pulses,     0);
    up = 1'b0;
    repeat (8) cycle();
    up = 1'b1;
    pulses = 0;
    repeat (8) cycle();
    check("repress_duty",   int'(duty), 1);
    check("repress_pulses", pulses,     1);
    up = 1'b0;
    repeat (8) cycle();

    // ---- random stimulus against the model ----
    for (int seg = 0; seg < 220; seg++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 99) < 6) mode = ~mode;
      up = (r < 30) || (r >= 55 && r < 60);
      dn = (r >= 30 && r < 60);
      repeat ($urandom_range(1, 12)) cycle();
    end
    up = 1'b0; dn = 1'b0; mode = 1'b0;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
